// File: rtl/typed_text_buffer_pkg.sv
// Shared constants, state encoding and slot packing helper for the typing-race
// text buffer.
package typed_text_buffer_pkg;

  localparam logic [4:0]   MAX_LEN    = 5'd25;
  localparam logic [4:0]   BLANK_CODE = 5'd30;
  localparam logic [4:0]   KEY_BS     = 5'd26;
  localparam logic [4:0]   KEY_CLR    = 5'd27;
  localparam logic [124:0] BLANK_TEXT = {25{BLANK_CODE}};

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_TYPING = 2'd1,
    ST_DONE   = 2'd2
  } tb_state_e;

  // Bit offset of a slot in the 125-bit packed bus.
  function automatic logic [6:0] slot_lsb(input logic [4:0] idx);
    return {2'b00, idx} * 7'd5;
  endfunction

endpackage

// File: rtl/typed_text_buffer_sat_counter16.sv
// 16-bit counter that sticks at all-ones, with a synchronous clear that wins
// over increment.
module sat_counter16 (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        inc_i,
  output logic [15:0] count_o
);

  logic [15:0] count_q;
  logic [15:0] count_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = 16'h0000;
    end else if (inc_i && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'h0001;
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= 16'h0000;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/typed_text_buffer.sv
// Typed-line buffer for the typing race: applies key events to a 25-slot letter
// buffer, tracks the matching prefix against the target and flags completion.
module typed_text_buffer
  import typed_text_buffer_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         key_valid_i,
  input  logic [4:0]   key_code_i,
  input  logic         new_target_i,
  input  logic [124:0] target_i,
  input  logic [4:0]   target_len_i,
  output logic [124:0] text_o,
  output logic [4:0]   len_o,
  output logic [4:0]   correct_cnt_o,
  output logic         error_o,
  output logic         full_o,
  output logic         done_o,
  output logic         locked_o,
  output logic [15:0]  keystrokes_o,
  output logic [15:0]  miss_count_o
);

  tb_state_e    state_q, state_d;
  logic [124:0] text_q,  text_d;
  logic [4:0]   len_q,   len_d;
  logic [4:0]   cc_q,    cc_d;
  logic         done_q,  done_d;
  logic         error_q, full_q, locked_q;
  logic         ks_inc_s, miss_inc_s, cnt_clr_s;
  logic [6:0]   cur_lsb_s, prev_lsb_s;

  assign cur_lsb_s  = slot_lsb(len_q);
  assign prev_lsb_s = slot_lsb(len_q - 5'd1);

  // Event decode and next-state computation; new_target outranks every key.
  always_comb begin
    text_d     = text_q;
    len_d      = len_q;
    cc_d       = cc_q;
    state_d    = state_q;
    done_d     = 1'b0;
    ks_inc_s   = 1'b0;
    miss_inc_s = 1'b0;
    cnt_clr_s  = 1'b0;
    if (new_target_i) begin
      text_d    = BLANK_TEXT;
      len_d     = 5'd0;
      cc_d      = 5'd0;
      state_d   = ST_EMPTY;
      cnt_clr_s = 1'b1;
    end else if (key_valid_i) begin
      case (key_code_i)
        KEY_CLR: begin
          text_d  = BLANK_TEXT;
          len_d   = 5'd0;
          cc_d    = 5'd0;
          state_d = ST_EMPTY;
        end
        KEY_BS: begin
          if ((len_q != 5'd0) && (state_q != ST_DONE)) begin
            text_d[prev_lsb_s +: 5] = BLANK_CODE;
            len_d = len_q - 5'd1;
            if (cc_q == len_q) begin
              cc_d = cc_q - 5'd1;
            end else begin
              cc_d = cc_q;
            end
            if (len_d == 5'd0) begin
              state_d = ST_EMPTY;
            end else begin
              state_d = ST_TYPING;
            end
          end else begin
            text_d = text_q;
          end
        end
        5'd28, 5'd29, 5'd30, 5'd31: begin
          text_d = text_q;
        end
        default: begin
          if ((len_q < MAX_LEN) && (state_q != ST_DONE)) begin
            text_d[cur_lsb_s +: 5] = key_code_i;
            len_d    = len_q + 5'd1;
            ks_inc_s = 1'b1;
            // Only a letter typed directly after an intact prefix can extend it.
            if ((cc_q == len_q) && (len_q < target_len_i) &&
                (target_i[cur_lsb_s +: 5] == key_code_i)) begin
              cc_d = cc_q + 5'd1;
            end else begin
              miss_inc_s = 1'b1;
            end
            if ((cc_d == target_len_i) && (target_len_i != 5'd0) &&
                (len_d == target_len_i)) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_TYPING;
            end
          end else begin
            text_d = text_q;
          end
        end
      endcase
    end else begin
      text_d = text_q;
    end
  end

  // Buffer, length, prefix and status flag registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_EMPTY;
      text_q   <= BLANK_TEXT;
      len_q    <= 5'd0;
      cc_q     <= 5'd0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      full_q   <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      text_q   <= text_d;
      len_q    <= len_d;
      cc_q     <= cc_d;
      done_q   <= done_d;
      error_q  <= (cc_d != len_d);
      full_q   <= (len_d == MAX_LEN);
      locked_q <= (state_d == ST_DONE);
    end
  end

  sat_counter16 u_keystrokes (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (cnt_clr_s),
    .inc_i   (ks_inc_s),
    .count_o (keystrokes_o)
  );

  sat_counter16 u_miss_count (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (cnt_clr_s),
    .inc_i   (miss_inc_s),
    .count_o (miss_count_o)
  );

  assign text_o        = text_q;
  assign len_o         = len_q;
  assign correct_cnt_o = cc_q;
  assign error_o       = error_q;
  assign full_o        = full_q;
  assign done_o        = done_q;
  assign locked_o      = locked_q;

endmodule

// File: tb/tb_typed_text_buffer.sv
// Directed bench for typed_text_buffer with hand-computed expectations.
module tb_typed_text_buffer;

  logic         clk;
  logic         rst_n;
  logic         key_valid;
  logic [4:0]   key_code;
  logic         new_target;
  logic [124:0] target;
  logic [4:0]   target_len;
  logic [124:0] text;
  logic [4:0]   len;
  logic [4:0]   correct_cnt;
  logic         error;
  logic         full;
  logic         done;
  logic         locked;
  logic [15:0]  keystrokes;
  logic [15:0]  miss_count;

  int checks = 0;
  int errors = 0;

  localparam logic [124:0] BLANK = {25{5'd30}};

  typed_text_buffer dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .key_valid_i   (key_valid),
    .key_code_i    (key_code),
    .new_target_i  (new_target),
    .target_i      (target),
    .target_len_i  (target_len),
    .text_o        (text),
    .len_o         (len),
    .correct_cnt_o (correct_cnt),
    .error_o       (error),
    .full_o        (full),
    .done_o        (done),
    .locked_o      (locked),
    .keystrokes_o  (keystrokes),
    .miss_count_o  (miss_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [124:0] mk3(input logic [4:0] a, input logic [4:0] b,
                                       input logic [4:0] c);
    return {{22{5'd30}}, c, b, a};
  endfunction

  task automatic chk(input string tag, input logic [124:0] obs, input logic [124:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic key(input logic [4:0] code);
    key_valid = 1'b1;
    key_code  = code;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
  endtask

  task automatic load_target(input logic [124:0] t, input logic [4:0] tl);
    target     = t;
    target_len = tl;
    new_target = 1'b1;
    @(posedge clk);
    #1;
    new_target = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    key_valid  = 1'b0;
    key_code   = 5'd0;
    new_target = 1'b0;
    target     = BLANK;
    target_len = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_text", text, BLANK);
    chk("rst_len", {120'd0, len}, {120'd0, 5'd0});
    chk("rst_cc", {120'd0, correct_cnt}, 125'd0);
    chk("rst_flags", {121'd0, error, full, done, locked}, 125'd0);
    chk("rst_cnts", {93'd0, keystrokes, miss_count}, 125'd0);
    rst_n = 1'b1;

    // Reset then type "CAT".
    load_target(mk3(5'd2, 5'd0, 5'd19), 5'd3);
    key(5'd2);
    chk("cat_len1", {120'd0, len}, {120'd0, 5'd1});
    chk("cat_cc1", {120'd0, correct_cnt}, {120'd0, 5'd1});
    chk("cat_done_early", {124'd0, done}, 125'd0);
    key(5'd0);
    key(5'd19);
    chk("cat_len3", {120'd0, len}, {120'd0, 5'd3});
    chk("cat_cc3", {120'd0, correct_cnt}, {120'd0, 5'd3});
    chk("cat_done", {124'd0, done}, {124'd0, 1'b1});
    chk("cat_locked", {124'd0, locked}, {124'd0, 1'b1});
    chk("cat_text", text, mk3(5'd2, 5'd0, 5'd19));
    idle();
    chk("cat_done_pulse", {124'd0, done}, 125'd0);
    chk("cat_still_locked", {124'd0, locked}, {124'd0, 1'b1});
    chk("cat_ks", {109'd0, keystrokes}, {109'd0, 16'd3});

    // Locked: letter and backspace ignored; clear keeps counters.
    key(5'd5);
    key(5'd26);
    chk("lock_len", {120'd0, len}, {120'd0, 5'd3});
    chk("lock_text", text, mk3(5'd2, 5'd0, 5'd19));
    chk("lock_ks", {109'd0, keystrokes}, {109'd0, 16'd3});
    chk("lock_done", {124'd0, done}, 125'd0);
    key(5'd27);
    chk("clr_text", text, BLANK);
    chk("clr_len", {120'd0, len}, 125'd0);
    chk("clr_locked", {124'd0, locked}, 125'd0);
    chk("clr_ks_kept", {109'd0, keystrokes}, {109'd0, 16'd3});
    key(5'd26);
    chk("bs_empty_len", {120'd0, len}, 125'd0);
    chk("bs_empty_text", text, BLANK);
    key(5'd29);
    chk("ignored_code", {93'd0, keystrokes, miss_count}, {93'd0, 16'd3, 16'd0});

    // Typo and correction.
    load_target(mk3(5'd2, 5'd0, 5'd19), 5'd3);
    chk("nt_ks_clr", {109'd0, keystrokes}, 125'd0);
    key(5'd2);
    key(5'd1);
    chk("typo_cc", {120'd0, correct_cnt}, {120'd0, 5'd1});
    chk("typo_error", {124'd0, error}, {124'd0, 1'b1});
    chk("typo_miss", {109'd0, miss_count}, {109'd0, 16'd1});
    key(5'd26);
    chk("bs_len", {120'd0, len}, {120'd0, 5'd1});
    chk("bs_error", {124'd0, error}, 125'd0);
    chk("bs_text", text, mk3(5'd2, 5'd30, 5'd30));
    key(5'd0);
    key(5'd19);
    chk("fix_done", {124'd0, done}, {124'd0, 1'b1});
    chk("fix_error", {124'd0, error}, 125'd0);
    chk("fix_ks", {109'd0, keystrokes}, {109'd0, 16'd4});
    chk("fix_miss", {109'd0, miss_count}, {109'd0, 16'd1});

    // Zero-length target: letters are misses, no completion.
    load_target(BLANK, 5'd0);
    key(5'd0);
    chk("tl0_miss", {109'd0, miss_count}, {109'd0, 16'd1});
    chk("tl0_done", {123'd0, done, locked}, 125'd0);

    // Overflow against a mismatching target.
    load_target({25{5'd3}}, 5'd25);
    for (int i = 0; i < 25; i++) key(5'd0);
    chk("ovf_len", {120'd0, len}, {120'd0, 5'd25});
    chk("ovf_full", {124'd0, full}, {124'd0, 1'b1});
    chk("ovf_text", text, {25{5'd0}});
    chk("ovf_cnts", {93'd0, keystrokes, miss_count}, {93'd0, 16'd25, 16'd25});
    key(5'd7);
    chk("ovf26_text", text, {25{5'd0}});
    chk("ovf26_ks", {109'd0, keystrokes}, {109'd0, 16'd25});
    chk("ovf26_len", {120'd0, len}, {120'd0, 5'd25});

    // new_target and key in the same cycle: key dropped.
    key_valid = 1'b1;
    key_code  = 5'd4;
    load_target(mk3(5'd2, 5'd0, 5'd19), 5'd3);
    key_valid = 1'b0;
    chk("sim_text", text, BLANK);
    chk("sim_len", {120'd0, len}, 125'd0);
    chk("sim_cnts", {93'd0, keystrokes, miss_count}, 125'd0);

    // Asynchronous reset mid-word.
    key(5'd2);
    key(5'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_text", text, BLANK);
    chk("arst_len_cc", {115'd0, len, correct_cnt}, 125'd0);
    chk("arst_ks", {109'd0, keystrokes}, 125'd0);
    idle();
    rst_n = 1'b1;
    key(5'd9);
    chk("post_rst_len", {120'd0, len}, {120'd0, 5'd1});
    chk("post_rst_text", text, mk3(5'd9, 5'd30, 5'd30));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
